// File: rtl/soc_system_led_out.sv
// ---------------------------------------------------------------------------
// soc_system_led_out
//
// Avalon-MM slave output port for board LEDs (or any static output pins).
// Provides a data register with atomic bit-set / bit-clear aliases and an
// optional hardware blink engine whose phase XORs selected output bits.
//
// Optional feature macro: SOC_SYSTEM_LED_BLINK_EN
//   defined     : blink engine plus BLINK_MASK / BLINK_PERIOD / STATUS registers
//   not defined : no counter or phase logic; out_port follows DATA only
//
// Register map (word addresses):
//   0 DATA          R/W  data[DATA_WIDTH-1:0]
//   1 BLINK_MASK    R/W  bits that blink (reads 0 without blink engine)
//   2 BLINK_PERIOD  R/W  24-bit half-period reload P (reads 0 without engine)
//   3 STATUS        RO   bit0 = phase (reads 0 without engine)
//   4 OUTSET        WO   data <= data | wd, reads 0
//   5 OUTCLEAR      WO   data <= data & ~wd, reads 0
//   6,7             --   read 0, writes ignored
//
// Parameters:
//   DATA_WIDTH   number of output bits (1..32)
//   RESET_VALUE  value of the data register and out_port at reset
//
// Ports:
//   clk         bus clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data (1-cycle latency, no wait states)
//   out_port    registered output pins
// ---------------------------------------------------------------------------
module soc_system_led_out #(
  parameter int          DATA_WIDTH  = 10,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd_data;

  assign wr_en   = chipselect & ~write_n;
  assign wd_data = writedata[DATA_WIDTH-1:0];

  // Upper write-data bits beyond the implemented registers are don't-care.
  logic unused_wd;
  assign unused_wd = ^writedata;

  // -------------------------------------------------------------------------
  // Data register with set / clear aliases
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;

  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_next = wd_data;
        ADDR_OUTSET:   data_next = data_reg | wd_data;
        ADDR_OUTCLEAR: data_next = data_reg & ~wd_data;
        default:       data_next = data_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RST_DATA;
    end else begin
      data_reg <= data_next;
    end
  end

  // Per-bit XOR term applied to data on its way to the pins.
  logic [DATA_WIDTH-1:0] blink_xor;

  // Read values of the blink registers, zero-extended to the bus width.
  logic [31:0] rd_mask;
  logic [31:0] rd_period;
  logic [31:0] rd_status;

`ifdef SOC_SYSTEM_LED_BLINK_EN
  // -------------------------------------------------------------------------
  // Blink engine
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] blink_mask_reg;
  logic [DATA_WIDTH-1:0] blink_mask_next;
  logic [23:0]           period_reg;
  logic [23:0]           period_next;
  logic [23:0]           cnt_reg;
  logic [23:0]           cnt_next;
  logic                  phase_reg;
  logic                  phase_next;

  always_comb begin
    blink_mask_next = blink_mask_reg;
    period_next     = period_reg;
    cnt_next        = cnt_reg;
    phase_next      = phase_reg;

    if (wr_en && (address == ADDR_MASK)) begin
      blink_mask_next = wd_data;
    end

    // A period write restarts the engine and wins over a toggle due on the
    // same edge, so the new half-period is always measured from the write.
    if (wr_en && (address == ADDR_PERIOD)) begin
      period_next = writedata[23:0];
      cnt_next    = writedata[23:0];
      phase_next  = 1'b0;
    end else if (period_reg == 24'd0) begin
      cnt_next   = 24'd0;
      phase_next = 1'b0;
    end else if (cnt_reg != 24'd0) begin
      cnt_next = cnt_reg - 24'd1;
    end else begin
      // Terminal count: reload and toggle, giving a toggle every P+1 cycles.
      cnt_next   = period_reg;
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask_reg <= '0;
      period_reg     <= 24'd0;
      cnt_reg        <= 24'd0;
      phase_reg      <= 1'b0;
    end else begin
      blink_mask_reg <= blink_mask_next;
      period_reg     <= period_next;
      cnt_reg        <= cnt_next;
      phase_reg      <= phase_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_blink_xor
      assign blink_xor[gi] = blink_mask_reg[gi] & phase_reg;
    end
  endgenerate

  always_comb begin
    rd_mask                   = '0;
    rd_mask[DATA_WIDTH-1:0]   = blink_mask_reg;
    rd_period                 = {8'd0, period_reg};
    rd_status                 = {31'd0, phase_reg};
  end
`else
  // -------------------------------------------------------------------------
  // No blink engine: pins follow DATA, blink registers read as zero.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_blink_xor
      assign blink_xor[gi] = 1'b0;
    end
  endgenerate

  assign rd_mask   = 32'd0;
  assign rd_period = 32'd0;
  assign rd_status = 32'd0;
`endif

  // -------------------------------------------------------------------------
  // Output pins: one register stage after data / phase.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] out_port_reg;
  logic [DATA_WIDTH-1:0] out_port_next;

  assign out_port_next = data_reg ^ blink_xor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port_reg <= RST_DATA;
    end else begin
      out_port_reg <= out_port_next;
    end
  end

  assign out_port = out_port_reg;

  // -------------------------------------------------------------------------
  // Read path: free-running mux of pre-edge register values, so a read and a
  // write to the same address in one cycle return the old contents.
  // -------------------------------------------------------------------------
  logic [31:0] rd_data_ext;
  logic [31:0] readdata_reg;
  logic [31:0] readdata_next;

  always_comb begin
    rd_data_ext                   = '0;
    rd_data_ext[DATA_WIDTH-1:0]   = data_reg;
  end

  always_comb begin
    readdata_next = 32'd0;
    case (address)
      ADDR_DATA:   readdata_next = rd_data_ext;
      ADDR_MASK:   readdata_next = rd_mask;
      ADDR_PERIOD: readdata_next = rd_period;
      ADDR_STATUS: readdata_next = rd_status;
      default:     readdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= 32'd0;
    end else begin
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;

endmodule

// File: tb/tb_soc_system_led_out.sv
// ---------------------------------------------------------------------------
// tb_soc_system_led_out
//
// Scoreboard bench: the driver issues one bus cycle per clock, asks the
// reference model what out_port and readdata must be after that edge and
// queues it; a monitor pops one entry per clock and compares. The model
// expresses the blink phase as a function of elapsed cycles since the last
// period write rather than as a counter.
// ---------------------------------------------------------------------------
module tb_soc_system_led_out;

  localparam int          DW = 10;
  localparam logic [31:0] RV = 32'h155;

`ifdef SOC_SYSTEM_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  soc_system_led_out #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned txn_idx  = 0;

  typedef struct {
    logic [DW-1:0] out;
    logic [31:0]   rd;
    int unsigned   idx;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_mask;
  longint        m_p;     // blink half-period
  longint        m_k;     // edge number of the last period write
  longint        m_edge;  // edges seen since reset release

  function automatic void m_reset();
    m_data = RV[DW-1:0];
    m_mask = '0;
    m_p    = 0;
    m_k    = 0;
    m_edge = 0;
  endfunction

  // Phase after edge m_edge: flips once per completed block of P+1 edges.
  function automatic bit m_phase();
    if (m_p == 0) return 1'b0;
    return (((m_edge - m_k) / (m_p + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      3'd0: v[DW-1:0] = m_data;
      3'd1: if (BLINK) v[DW-1:0] = m_mask;
      3'd2: if (BLINK) v = 32'(m_p);
      3'd3: if (BLINK) v = {31'd0, m_phase()};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic void check(input string name, input int unsigned idx,
                                input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s txn=%0d got=0x%08h exp=0x%08h", name, idx, got, exp);
  endfunction

  // One bus cycle: drive inputs at the falling edge, predict the result of
  // the next rising edge, advance the model, wait for the next falling edge.
  task automatic drive(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd);
    exp_t e;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    e.out = m_data ^ (m_phase() ? m_mask : '0);
    e.rd  = m_read(a);
    e.idx = txn_idx++;
    sb_q.push_back(e);
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[DW-1:0];
        3'd1: if (BLINK) m_mask = wd[DW-1:0];
        3'd2: if (BLINK) begin m_p = longint'(wd[23:0]); m_k = m_edge + 1; end
        3'd4: m_data = m_data | wd[DW-1:0];
        3'd5: m_data = m_data & ~wd[DW-1:0];
        default: ;
      endcase
    end
    m_edge++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    drive(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      $display("FAIL drain got=%0d pending exp=0", sb_q.size());
      n_checks++;
      sb_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_port", e.idx, 32'(out_port), 32'(e.out));
        check("readdata", e.idx, readdata, e.rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  a;
    logic [31:0] wd;

    // Power-on reset
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_port", 0, 32'(out_port), RV & 32'h3FF);
    check("rst_readdata", 0, readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_reset();

    // Data path
    wr(3'd0, 32'h2A5);
    rd(3'd0);
    rd(3'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0);
    rd(3'd0);

    // Set / clear, read-only aliases and unused addresses
    wr(3'd0, 32'h0F0);
    wr(3'd4, 32'h003);
    wr(3'd5, 32'h030);
    rd(3'd4);
    rd(3'd5);
    rd(3'd0);
    wr(3'd6, 32'h3FF);
    rd(3'd6);
    rd(3'd7);
    rd(3'd0);

    // Blink P=3: toggles every 4 edges, then stop with P=0
    wr(3'd0, 32'h001);
    wr(3'd1, 32'h300);
    wr(3'd2, 32'd3);
    for (int i = 0; i < 14; i++) rd(3'd3);
    wr(3'd2, 32'd0);
    for (int i = 0; i < 6; i++) rd(3'd0);

    // Collision: OUTSET on the same edge as the 0->1 toggle
    wr(3'd2, 32'd3);
    rd(3'd3);
    rd(3'd3);
    rd(3'd3);
    wr(3'd4, 32'h004);
    rd(3'd0);
    rd(3'd3);
    // Period rewrite mid-count restarts and clears phase
    rd(3'd3);
    wr(3'd2, 32'd2);
    for (int i = 0; i < 8; i++) rd(3'd3);
    // Mask write on a toggle edge
    wr(3'd1, 32'h0FF);
    for (int i = 0; i < 6; i++) rd(3'd1);

    // Read-during-write returns old value
    wr(3'd0, 32'h111);
    wr(3'd0, 32'h222);
    rd(3'd0);

    // Randomized traffic, short periods so toggles are frequent
    for (int i = 0; i < 400; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = $urandom_range(0, 6);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
    end

    // Asynchronous reset in the middle of a blink
    wr(3'd1, 32'h3FF);
    wr(3'd2, 32'd5);
    for (int i = 0; i < 8; i++) rd(3'd3);
    drain();
    reset_n = 1'b0;
    #1;
    check("async_rst_out_port", txn_idx, 32'(out_port), RV & 32'h3FF);
    check("async_rst_readdata", txn_idx, readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    rd(3'd3);
    rd(3'd2);
    rd(3'd1);
    for (int i = 0; i < 4; i++) rd(3'd0);

    // Mask / period writes: blink build blinks, plain build ignores them
    wr(3'd1, 32'h3FF);
    wr(3'd2, 32'd2);
    rd(3'd1);
    rd(3'd2);
    rd(3'd3);
    for (int i = 0; i < 100; i++) rd(3'($urandom_range(0, 3)));

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
